// File: rtl/alu_sequencer.sv
// Z8 execute stage: fetches operands, drives the external ALU,
// writes results back and owns the FLAGS register.
package alu_pkg;
  localparam logic [4:0] ALU2_ADD  = 5'h00;
  localparam logic [4:0] ALU2_ADC  = 5'h01;
  localparam logic [4:0] ALU2_SUB  = 5'h02;
  localparam logic [4:0] ALU2_SBC  = 5'h03;
  localparam logic [4:0] ALU2_OR   = 5'h04;
  localparam logic [4:0] ALU2_AND  = 5'h05;
  localparam logic [4:0] ALU2_TCM  = 5'h06;
  localparam logic [4:0] ALU2_TM   = 5'h07;
  localparam logic [4:0] ALU2_CP   = 5'h08;
  localparam logic [4:0] ALU2_XOR  = 5'h09;
  localparam logic [4:0] ALU1_INC  = 5'h10;
  localparam logic [4:0] ALU1_DEC  = 5'h11;
  localparam logic [4:0] ALU1_DA   = 5'h12;
  localparam logic [4:0] ALU1_DA_H = 5'h13;
  localparam logic [4:0] ALU1_INCW = 5'h14;
  localparam logic [4:0] ALU1_DECW = 5'h15;
  localparam logic [4:0] ALU1_COM  = 5'h16;
  localparam logic [4:0] ALU1_CLR  = 5'h17;
endpackage

module alu_sequencer
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       ready,
  input  logic [4:0] op,
  input  logic [7:0] dst,
  input  logic [7:0] src,
  input  logic [7:0] imm,
  input  logic       useImm,
  input  logic       word,
  output logic [7:0] regAddr,
  input  logic [7:0] regRdData,
  output logic       regWrEn,
  output logic [7:0] regWrData,
  output logic [4:0] aluMode,
  output logic [7:0] aluA,
  output logic [7:0] aluB,
  output logic [7:0] aluFlags,
  input  logic [7:0] aluOut,
  input  logic [7:0] aluOutFlags,
  input  logic       flagsWrEn,
  input  logic [7:0] flagsWrData,
  output logic [7:0] flags,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE, RDA, RDB, EXE, EXE2, WB
  } state_t;

  state_t     state, state_nx;
  logic [4:0] op_q;
  logic [7:0] dst_q, src_q, imm_q;
  logic       use_imm_q, word_q;
  logic [7:0] a_q, h_q, r_q, f_q;

  logic       is_da, flag_only;
  logic [7:0] lo_addr, hi_addr;

  assign is_da     = (op_q == ALU1_DA);
  assign flag_only = (op_q == ALU2_CP) ||
                     (op_q == ALU2_TM) ||
                     (op_q == ALU2_TCM);
  // Z8 pairs are big-endian: high byte at the even address
  assign lo_addr   = {dst_q[7:1], 1'b1};
  assign hi_addr   = {dst_q[7:1], 1'b0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op_q      <= '0;
      dst_q     <= '0;
      src_q     <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      word_q    <= 1'b0;
      a_q       <= '0;
      h_q       <= '0;
      r_q       <= '0;
      f_q       <= '0;
      flags     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        op_q      <= op;
        dst_q     <= dst;
        src_q     <= src;
        imm_q     <= imm;
        use_imm_q <= useImm;
        word_q    <= word;
      end
      if (state == RDB) a_q <= regRdData;
      if (state == EXE) begin
        r_q <= aluOut;
        if (word_q) h_q <= regRdData;
        else        f_q <= aluOutFlags;
      end
      if (state == EXE2) begin
        r_q <= aluOut;
        f_q <= aluOutFlags;
      end
      if (state == WB)    flags <= f_q;
      else if (flagsWrEn) flags <= flagsWrData;
    end
  end

  always_comb begin
    state_nx  = state;
    ready     = 1'b0;
    regAddr   = '0;
    regWrEn   = 1'b0;
    regWrData = '0;
    aluMode   = '0;
    aluA      = '0;
    aluB      = '0;
    aluFlags  = flags;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nx = RDA;
      end
      RDA: begin
        regAddr  = word_q ? lo_addr : dst_q;
        state_nx = RDB;
      end
      RDB: begin
        regAddr  = word_q ? hi_addr : src_q;
        state_nx = EXE;
      end
      EXE: begin
        aluA = a_q;
        if (word_q) begin
          aluMode = (op_q == ALU1_DECW) ? ALU1_DEC : ALU1_INC;
        end else begin
          aluMode = op_q;
          aluB    = use_imm_q ? imm_q : regRdData;
        end
        state_nx = (word_q || is_da) ? EXE2 : WB;
      end
      EXE2: begin
        if (word_q) begin
          regAddr   = lo_addr;
          regWrEn   = 1'b1;
          regWrData = r_q;
          aluMode   = op_q;
          aluA      = h_q;
          aluB      = r_q;
        end else begin
          aluMode  = ALU1_DA_H;
          aluA     = r_q;
          aluFlags = f_q;
        end
        state_nx = WB;
      end
      WB: begin
        regAddr   = word_q ? hi_addr : dst_q;
        regWrEn   = !flag_only;
        regWrData = r_q;
        done      = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU and register file,
// scoreboard of expected writes/completions checked by a monitor.
`timescale 1ns/1ps
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int FC = 7, FZ = 6, FS = 5, FV = 4, FD = 3, FH = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       ready;
  logic [4:0] op;
  logic [7:0] dst, src, imm;
  logic       useImm, word;
  logic [7:0] regAddr, regRdData, regWrData;
  logic       regWrEn;
  logic [4:0] aluMode;
  logic [7:0] aluA, aluB, aluFlags;
  logic [7:0] alu_out, alu_of;
  logic       flagsWrEn;
  logic [7:0] flagsWrData;
  logic [7:0] flags;
  logic       done;

  logic [7:0] rf [256];
  logic       ld_en;
  logic [7:0] ld_addr, ld_data;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    int         lat;
  } exp_t;
  exp_t sbq[$];

  int ncmp = 0, nerr = 0;
  int cyc = 0, acc = 0, nacc = 0;
  logic       chk_pend = 1'b0;
  logic [7:0] exp_flags = '0;
  logic [8:0] s;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .reset(rst_n), .start(start), .ready(ready),
    .op(op), .dst(dst), .src(src), .imm(imm),
    .useImm(useImm), .word(word),
    .regAddr(regAddr), .regRdData(regRdData),
    .regWrEn(regWrEn), .regWrData(regWrData),
    .aluMode(aluMode), .aluA(aluA), .aluB(aluB),
    .aluFlags(aluFlags), .aluOut(alu_out),
    .aluOutFlags(alu_of), .flagsWrEn(flagsWrEn),
    .flagsWrData(flagsWrData), .flags(flags), .done(done)
  );

  always @(posedge clk) begin
    regRdData <= rf[regAddr];
    if (regWrEn) rf[regAddr] <= regWrData;
    if (ld_en)   rf[ld_addr] <= ld_data;
  end

  always_comb begin
    s       = '0;
    alu_out = aluA;
    alu_of  = aluFlags;
    case (aluMode)
      ALU2_ADD: begin
        s = {1'b0, aluA} + {1'b0, aluB};
        alu_out    = s[7:0];
        alu_of[FC] = s[8];
        alu_of[FH] = ({1'b0, aluA[3:0]} + {1'b0, aluB[3:0]}) > 5'd15;
        alu_of[FV] = (aluA[7] == aluB[7]) && (s[7] != aluA[7]);
        alu_of[FD] = 1'b0;
        alu_of[FZ] = (s[7:0] == 8'h00);
        alu_of[FS] = s[7];
      end
      ALU2_SUB, ALU2_CP: begin
        s = {1'b0, aluA} - {1'b0, aluB};
        alu_out    = (aluMode == ALU2_CP) ? aluA : s[7:0];
        alu_of[FC] = s[8];
        alu_of[FV] = (aluA[7] != aluB[7]) && (s[7] != aluA[7]);
        alu_of[FZ] = (s[7:0] == 8'h00);
        alu_of[FS] = s[7];
        if (aluMode == ALU2_SUB) begin
          alu_of[FH] = aluA[3:0] < aluB[3:0];
          alu_of[FD] = 1'b1;
        end
      end
      ALU1_INC: begin
        alu_out    = aluA + 8'h01;
        alu_of[FZ] = (alu_out == 8'h00);
        alu_of[FS] = alu_out[7];
        alu_of[FV] = (aluA == 8'h7F);
      end
      ALU1_DEC: begin
        alu_out    = aluA - 8'h01;
        alu_of[FZ] = (alu_out == 8'h00);
        alu_of[FS] = alu_out[7];
        alu_of[FV] = (aluA == 8'h80);
      end
      ALU1_INCW: begin
        alu_out    = aluA + {7'd0, aluB == 8'h00};
        alu_of[FZ] = (alu_out == 8'h00) && (aluB == 8'h00);
        alu_of[FS] = alu_out[7];
        alu_of[FV] = (aluB == 8'h00) && (aluA == 8'h7F);
      end
      ALU1_DECW: begin
        alu_out    = aluA - {7'd0, aluB == 8'hFF};
        alu_of[FZ] = (alu_out == 8'h00) && (aluB == 8'h00);
        alu_of[FS] = alu_out[7];
        alu_of[FV] = (aluB == 8'hFF) && (aluA == 8'h80);
      end
      ALU1_DA: begin
        alu_out = aluA +
          ((aluFlags[FH] || aluA[3:0] > 4'd9) ? 8'h06 : 8'h00);
        alu_of[FC] = aluFlags[FC] || (aluA > 8'h99);
      end
      ALU1_DA_H: begin
        alu_out    = aluA + (aluFlags[FC] ? 8'h60 : 8'h00);
        alu_of[FZ] = (alu_out == 8'h00);
        alu_of[FS] = alu_out[7];
      end
      default: ;
    endcase
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pop_check(input logic wr, input logic [7:0] a,
                           input logic [7:0] d);
    exp_t e;
    int lat;
    lat = cyc - acc + 1;
    ncmp++;
    if (sbq.size() == 0) begin
      nerr++;
      $display("FAIL unexpected_%s: addr=%h data=%h lat=%0d, none expected",
               wr ? "write" : "done", a, d, lat);
      return;
    end
    e = sbq.pop_front();
    if (e.wr != wr || e.lat != lat ||
        (wr && (e.addr !== a || e.data !== d))) begin
      nerr++;
      $display("FAIL sb_event: got wr=%0d addr=%h data=%h lat=%0d expected wr=%0d addr=%h data=%h lat=%0d",
               wr, a, d, lat, e.wr, e.addr, e.data, e.lat);
    end
    if (!wr && !e.wr) begin
      exp_flags = e.data;
      chk_pend  = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_pend) begin
      chk_pend = 1'b0;
      cmp("flags_after_done", flags, exp_flags);
      cmp("done_one_cycle", {7'd0, done}, 8'd0);
      cmp("ready_after_done", {7'd0, ready}, 8'd1);
    end
    if (rst_n && start && ready) begin
      acc = cyc + 1;
      nacc++;
    end
    if (rst_n && regWrEn) pop_check(1'b1, regAddr, regWrData);
    if (rst_n && done)    pop_check(1'b0, 8'h00, 8'h00);
  end

  task automatic exp_wr(input logic [7:0] a, input logic [7:0] d,
                        input int lat);
    exp_t e;
    e.wr = 1'b1; e.addr = a; e.data = d; e.lat = lat;
    sbq.push_back(e);
  endtask

  task automatic exp_done(input logic [7:0] f, input int lat);
    exp_t e;
    e.wr = 1'b0; e.addr = 8'h00; e.data = f; e.lat = lat;
    sbq.push_back(e);
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic set_cmd(input logic [4:0] o, input logic [7:0] d,
                         input logic [7:0] sr, input logic [7:0] im,
                         input logic ui, input logic w);
    op = o; dst = d; src = sr; imm = im; useImm = ui; word = w;
  endtask

  task automatic issue_only(input logic [4:0] o, input logic [7:0] d,
                            input logic [7:0] sr, input logic [7:0] im,
                            input logic ui, input logic w);
    set_cmd(o, d, sr, im, ui, w);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      ncmp++;
      nerr++;
      $display("FAIL %s_timeout: done not seen within 12 cycles", nm);
    end
    @(posedge clk); #1;
  endtask

  task automatic issue(input string nm, input logic [4:0] o,
                       input logic [7:0] d, input logic [7:0] sr,
                       input logic [7:0] im, input logic ui,
                       input logic w);
    issue_only(o, d, sr, im, ui, w);
    wait_done(nm);
  endtask

  task automatic fwr(input logic [7:0] d);
    flagsWrEn = 1'b1; flagsWrData = d;
    @(posedge clk); #1;
    flagsWrEn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    rst_n = 1'b0; start = 1'b0;
    set_cmd(5'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    flagsWrEn = 1'b0; flagsWrData = 8'h00;
    ld_en = 1'b0; ld_addr = 8'h00; ld_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_ready", {7'd0, ready}, 8'd1);
    cmp("rst_flags", flags, 8'h00);
    cmp("rst_regwr", {7'd0, regWrEn}, 8'd0);
    cmp("rst_done", {7'd0, done}, 8'd0);
    cmp("rst_regaddr", regAddr, 8'h00);
    cmp("rst_alu_ab", aluA | aluB, 8'h00);
    cmp("rst_alumode", {3'd0, aluMode}, 8'h00);

    poke(8'h10, 8'h3A); poke(8'h11, 8'h4C);
    poke(8'h20, 8'h05);
    poke(8'h30, 8'h12); poke(8'h31, 8'hFF);
    poke(8'h40, 8'h00); poke(8'h41, 8'h01);
    poke(8'h50, 8'h9A);
    poke(8'h12, 8'h3A); poke(8'h13, 8'h4C);
    poke(8'h14, 8'h01); poke(8'h15, 8'h02);
    poke(8'h16, 8'h55); poke(8'h17, 8'h01);
    poke(8'h18, 8'h10);
    rst_n = 1'b1;
    @(posedge clk); #1;

    exp_wr(8'h10, 8'h86, 4); exp_done(8'h34, 4);
    issue("add", ALU2_ADD, 8'h10, 8'h11, 8'h00, 1'b0, 1'b0);

    exp_done(8'h44, 4);
    issue("cp", ALU2_CP, 8'h20, 8'h00, 8'h05, 1'b1, 1'b0);

    fwr(8'h00);
    cmp("flags_ext_zero", flags, 8'h00);

    exp_wr(8'h31, 8'h00, 4); exp_wr(8'h30, 8'h13, 5);
    exp_done(8'h00, 5);
    issue("incw", ALU1_INCW, 8'h31, 8'h00, 8'h00, 1'b0, 1'b1);

    exp_wr(8'h41, 8'h00, 4); exp_wr(8'h40, 8'h00, 5);
    exp_done(8'h40, 5);
    issue("decw", ALU1_DECW, 8'h40, 8'h00, 8'h00, 1'b0, 1'b1);

    exp_wr(8'h50, 8'h00, 5); exp_done(8'hC0, 5);
    issue("da", ALU1_DA, 8'h50, 8'h00, 8'h00, 1'b0, 1'b0);

    fwr(8'hFF);
    cmp("flags_ext_ff", flags, 8'hFF);

    // external flags load collides with WB: WB must win
    exp_wr(8'h12, 8'h86, 4); exp_done(8'h37, 4);
    issue_only(ALU2_ADD, 8'h12, 8'h13, 8'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    flagsWrEn = 1'b1; flagsWrData = 8'hFF;
    wait_done("add_wbflags");
    flagsWrEn = 1'b0;

    n0 = nacc;
    exp_wr(8'h14, 8'h03, 4); exp_done(8'h03, 4);
    set_cmd(ALU2_ADD, 8'h14, 8'h15, 8'h00, 1'b0, 1'b0);
    start = 1'b1;
    wait_done("held_start");
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp("held_start_accepts", 8'(nacc - n0), 8'd1);

    issue_only(ALU2_ADD, 8'h16, 8'h17, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    cmp("midrst_regwr", {7'd0, regWrEn}, 8'd0);
    cmp("midrst_flags", flags, 8'h00);
    cmp("midrst_ready", {7'd0, ready}, 8'd1);
    cmp("midrst_done", {7'd0, done}, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    cmp("midrst_reg16", rf[8'h16], 8'h55);

    exp_wr(8'h18, 8'h0F, 4); exp_done(8'h0C, 4);
    issue("sub", ALU2_SUB, 8'h18, 8'h00, 8'h01, 1'b1, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    cmp("reg10", rf[8'h10], 8'h86);
    cmp("reg20_unchanged", rf[8'h20], 8'h05);
    cmp("reg30", rf[8'h30], 8'h13);
    cmp("reg31", rf[8'h31], 8'h00);
    cmp("reg50", rf[8'h50], 8'h00);
    cmp("sb_leftover", 8'(sbq.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
